// File: rtl/spi_mem_write_sched.sv
// spi_mem_write_sched: round-robin scheduler turning two word-write requesters into SPI memory write frames.
// Define SPI_SCHED_WREN_EN to send a write-enable frame ahead of every write frame.
module spi_mem_write_sched #(
    parameter logic [7:0] WREN_CMD  = 8'h06,
    parameter logic [7:0] WRITE_CMD = 8'h02,
    parameter int         CS_GAP    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic [15:0] DATA0,
    input  logic [17:0] ADDR0,
    output logic        ACK0,
    input  logic        REQ1,
    input  logic [15:0] DATA1,
    input  logic [17:0] ADDR1,
    output logic        ACK1,
    output logic        TX_VALID,
    output logic [7:0]  TX_BYTE,
    input  logic        TX_READY,
    output logic        CS_N,
    output logic        BUSY,
    output logic [15:0] WRITE_COUNT
);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SEND = 3'd2, DRAIN = 3'd3, GAP = 3'd4;

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [3:0]  gap_cnt;
    logic [17:0] addr;
    logic [15:0] data;
    logic [15:0] count;
    logic        last;
    logic        pick;
    logic        phase;
    logic        last_byte;
    logic        ack;
    logic [7:0]  byte_sel;

`ifndef SPI_SCHED_WREN_EN
    assign phase = 1'b1;
`endif

    // last doubles as the current grantee once a frame is under way
    assign pick      = (REQ0 && REQ1) ? !last : REQ1;
    assign last_byte = phase ? (idx == 3'd5) : 1'b1;
    assign byte_sel  = !phase      ? WREN_CMD :
                       idx == 3'd0 ? WRITE_CMD :
                       idx == 3'd1 ? {6'b0, addr[17:16]} :
                       idx == 3'd2 ? addr[15:8] :
                       idx == 3'd3 ? addr[7:0] :
                       idx == 3'd4 ? data[15:8] : data[7:0];

    assign ack         = state == GAP && gap_cnt == 4'd0 && phase;
    assign ACK0        = ack && !last;
    assign ACK1        = ack && last;
    assign TX_VALID    = state == SEND;
    assign TX_BYTE     = TX_VALID ? byte_sel : 8'h00;
    assign CS_N        = !(state == SETUP || state == SEND || state == DRAIN);
    assign BUSY        = state != IDLE;
    assign WRITE_COUNT = count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            addr    <= '0;
            data    <= '0;
            count   <= '0;
            last    <= 1'b1;
`ifdef SPI_SCHED_WREN_EN
            phase   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (REQ0 || REQ1) begin
                    last  <= pick;
                    addr  <= pick ? ADDR1 : ADDR0;
                    data  <= pick ? DATA1 : DATA0;
`ifdef SPI_SCHED_WREN_EN
                    phase <= 1'b0;
`endif
                    state <= SETUP;
                end
                SETUP: begin
                    idx   <= 3'd0;
                    state <= SEND;
                end
                SEND: if (TX_READY) begin
                    idx   <= idx + 3'd1;
                    state <= last_byte ? DRAIN : SEND;
                end
                DRAIN: if (TX_READY) begin
                    gap_cnt <= '0;
                    count   <= phase ? count + 16'd1 : count;
                    state   <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == 4'(CS_GAP - 1)) begin
                        state <= phase ? IDLE : SETUP;
`ifdef SPI_SCHED_WREN_EN
                        phase <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
